// File: rtl/seq_muldiv_alu.sv
// Multi-cycle signed DIV/MUL/REM/MULH on L-bit operands: one shift-add or
// restoring-divide step per clock, Start/Busy/Done handshake, flag-word pass-through.
//
// state | meaning
// IDLE  | waiting for Start, Busy=0
// RUN   | L iterations on operand magnitudes
// SIGN  | apply sign, build flags, register R/FlagsOut and pulse Done
module seq_muldiv_alu #(
  parameter int L      = 16,
  parameter int OpBits = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [OpBits-1:0] Operation,
  input  logic [L-1:0]      A,
  input  logic [L-1:0]      B,
  input  logic [L-1:0]      FlagsIn,
  output logic              Busy,
  output logic              Done,
  output logic [L-1:0]      R,
  output logic [L-1:0]      FlagsOut
);

  localparam int CW = $clog2(L);
  localparam logic [OpBits-1:0] OP_DIV  = OpBits'(0);
  localparam logic [OpBits-1:0] OP_MUL  = OpBits'(1);
  localparam logic [OpBits-1:0] OP_REM  = OpBits'(2);
  localparam logic [OpBits-1:0] OP_MULH = OpBits'(3);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SIGN} state_t;

  state_t            state_q, state_d;
  logic [OpBits-1:0] op_q, op_d;
  logic [L-1:0]      a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [L-1:0]      fin_q, fin_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [L-1:0]      acc_q, acc_d, lo_q, lo_d;
  logic [L-1:0]      r_q, r_d, fo_q, fo_d;
  logic              done_q, done_d;

  logic              is_mul, neg_w;
  logic [L-1:0]      a_abs, b_abs, q_w, rm_w, res_w;
  logic [L:0]        add_w, shift_w, sub_w;
  logic [2*L-1:0]    prod_w, sprod_w;
  logic [3:0]        flg_w;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    fin_d   = fin_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    r_d     = r_q;
    fo_d    = fo_q;
    done_d  = 1'b0;

    a_abs   = A[L-1] ? -A : A;
    b_abs   = B[L-1] ? -B : B;
    is_mul  = (op_q == OP_MUL) || (op_q == OP_MULH);
    neg_w   = sa_q ^ sb_q;
    add_w   = {1'b0, acc_q} + {1'b0, a_mag_q};
    shift_w = {acc_q, lo_q[L-1]};
    sub_w   = shift_w - {1'b0, b_mag_q};
    prod_w  = {acc_q, lo_q};
    // Two's-complement negation of zero is zero, so no -0 can arise.
    sprod_w = neg_w ? -prod_w : prod_w;
    q_w     = neg_w ? -lo_q : lo_q;
    rm_w    = sa_q ? -acc_q : acc_q;
    res_w   = '0;
    flg_w   = fin_q[3:0];

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_RUN;
          op_d    = Operation;
          sa_d    = A[L-1];
          sb_d    = B[L-1];
          a_mag_d = a_abs;
          b_mag_d = b_abs;
          fin_d   = FlagsIn;
          cnt_d   = CW'(L - 1);
          acc_d   = '0;
          lo_d    = ((Operation == OP_MUL) || (Operation == OP_MULH)) ? b_abs : a_abs;
        end
      end
      S_RUN: begin
        if (is_mul) begin
          if (lo_q[0]) begin
            acc_d = add_w[L:1];
            lo_d  = {add_w[0], lo_q[L-1:1]};
          end else begin
            acc_d = {1'b0, acc_q[L-1:1]};
            lo_d  = {acc_q[0], lo_q[L-1:1]};
          end
        end else if (!sub_w[L]) begin
          acc_d = sub_w[L-1:0];
          lo_d  = {lo_q[L-2:0], 1'b1};
        end else begin
          acc_d = shift_w[L-1:0];
          lo_d  = {lo_q[L-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = S_SIGN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_SIGN: begin
        case (op_q)
          OP_DIV, OP_REM: begin
            if (b_mag_q == '0) begin
              res_w      = '0;
              flg_w[2:0] = 3'b010;
            end else begin
              res_w    = (op_q == OP_DIV) ? q_w : rm_w;
              flg_w[0] = |acc_q;
              flg_w[1] = 1'b0;
              // Only |A|=2^(L-1), |B|=1 with positive sign overflows the quotient.
              flg_w[2] = (op_q == OP_DIV) && lo_q[L-1] && !neg_w;
            end
          end
          OP_MUL: begin
            res_w    = sprod_w[L-1:0];
            flg_w[3] = !((&sprod_w[2*L-1:L-1]) || !(|sprod_w[2*L-1:L-1]));
          end
          default: res_w = sprod_w[2*L-1:L];
        endcase
        r_d     = res_w;
        fo_d    = {fin_q[L-1:4], flg_w};
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_mag_q <= '0;
      b_mag_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      fin_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      r_q     <= '0;
      fo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      fin_q   <= fin_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      r_q     <= r_d;
      fo_q    <= fo_d;
      done_q  <= done_d;
    end
  end

  assign Busy     = (state_q != S_IDLE);
  assign Done     = done_q;
  assign R        = r_q;
  assign FlagsOut = fo_q;

endmodule

// File: tb/tb_seq_muldiv_alu.sv
// Directed-vector bench for seq_muldiv_alu (L=16) with hand-computed results,
// latency, ignored-Start, back-to-back and mid-operation reset checks.
module tb_seq_muldiv_alu;

  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [1:0]  Operation;
  logic [15:0] A, B, FlagsIn;
  logic        Busy, Done;
  logic [15:0] R, FlagsOut;

  int n_tests = 0;
  int n_fail  = 0;

  seq_muldiv_alu #(.L(16), .OpBits(2)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Operation(Operation),
    .A(A), .B(B), .FlagsIn(FlagsIn),
    .Busy(Busy), .Done(Done), .R(R), .FlagsOut(FlagsOut)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an op, wait for the accept edge, then count edges until Done.
  task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] fi, output logic [15:0] r, output logic [15:0] fo,
                       output int lat);
    @(negedge Clk);
    Start = 1'b1; Operation = op; A = a; B = b; FlagsIn = fi;
    @(posedge Clk); #1;
    Start = 1'b0;
    lat = 0;
    while (!Done && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
    r  = R;
    fo = FlagsOut;
  endtask

  task automatic op_check(input string tag, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] fi,
                          input logic [15:0] exp_r, input logic [15:0] exp_f);
    logic [15:0] r, fo;
    int lat;
    do_op(op, a, b, fi, r, fo, lat);
    check({tag, "_lat"}, lat, 17);
    check({tag, "_r"}, r, exp_r);
    check({tag, "_flags"}, fo, exp_f);
  endtask

  initial begin
    logic [15:0] r, fo;
    int lat, pulses;

    Reset = 1'b1; Start = 1'b0; Operation = '0; A = '0; B = '0; FlagsIn = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_r", R, 0);
    check("rst_flags", FlagsOut, 0);

    op_check("mul_7x-3",   2'd1, 16'd7,    16'hFFFD, 16'hABC7, 16'hFFEB, 16'hABC7);
    op_check("div_-7/2",   2'd0, 16'hFFF9, 16'd2,    16'h0008, 16'hFFFD, 16'h0009);
    op_check("rem_-7%2",   2'd2, 16'hFFF9, 16'd2,    16'h0000, 16'hFFFF, 16'h0001);
    op_check("div_6/3",    2'd0, 16'd6,    16'd3,    16'h0007, 16'h0002, 16'h0000);
    op_check("div_5/0",    2'd0, 16'd5,    16'd0,    16'h0000, 16'h0000, 16'h0002);
    op_check("rem_5%0",    2'd2, 16'd5,    16'd0,    16'h0001, 16'h0000, 16'h0002);
    op_check("div_min/-1", 2'd0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 16'h0004);
    op_check("rem_min%-1", 2'd2, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
    op_check("mul_300sq",  2'd1, 16'd300,  16'd300,  16'h1230, 16'h5F90, 16'h1238);
    op_check("mulh_300sq", 2'd3, 16'd300,  16'd300,  16'h1235, 16'h0001, 16'h1235);
    op_check("mul_min*-1", 2'd1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 16'h0008);
    op_check("mulh_min*-1",2'd3, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
    op_check("mul_0x-5",   2'd1, 16'd0,    16'hFFFB, 16'h0000, 16'h0000, 16'h0000);
    op_check("mulh_-1x5",  2'd3, 16'hFFFF, 16'd5,    16'h0000, 16'hFFFF, 16'h0000);
    op_check("div_-100/7", 2'd0, 16'hFF9C, 16'd7,    16'h0000, 16'hFFF2, 16'h0001);
    op_check("rem_-100%7", 2'd2, 16'hFF9C, 16'd7,    16'h0000, 16'hFFFE, 16'h0000 | 16'h0001);

    // Start pulsed while busy must be ignored and not queued.
    @(negedge Clk);
    Start = 1'b1; Operation = 2'd0; A = 16'd100; B = 16'd7; FlagsIn = 16'h0000;
    @(posedge Clk); #1;
    Start = 1'b0;
    check("busy_after_accept", Busy, 1);
    repeat (4) @(posedge Clk);
    #1 Start = 1'b1; Operation = 2'd1; A = 16'd3; B = 16'd5; FlagsIn = 16'hFFF0;
    @(posedge Clk); #1 Start = 1'b0;
    lat = 5;
    while (!Done && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
    check("ign_lat", lat, 17);
    check("ign_r", R, 16'h000E);
    check("ign_flags", FlagsOut, 16'h0001);
    pulses = 0;
    repeat (25) begin
      @(posedge Clk); #1;
      if (Done) pulses++;
    end
    check("ign_no_queue", pulses, 0);
    check("ign_r_held", R, 16'h000E);

    // Start held in the Done cycle starts a second operation.
    do_op(2'd1, 16'd7, 16'hFFFD, 16'h0000, r, fo, lat);
    check("b2b_first_r", r, 16'hFFEB);
    check("b2b_busy_in_done", Busy, 0);
    Start = 1'b1; Operation = 2'd0; A = 16'hFFF9; B = 16'd2; FlagsIn = 16'h0000;
    @(posedge Clk); #1;
    Start = 1'b0;
    check("b2b_accepted", Busy, 1);
    lat = 0;
    while (!Done && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
    check("b2b_lat", lat, 17);
    check("b2b_r", R, 16'hFFFD);
    check("b2b_flags", FlagsOut, 16'h0001);

    // Reset during RUN aborts with no Done and clears outputs.
    @(negedge Clk);
    Start = 1'b1; Operation = 2'd0; A = 16'd100; B = 16'd7; FlagsIn = 16'hFFF0;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (7) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    check("rstmid_busy", Busy, 0);
    check("rstmid_done", Done, 0);
    check("rstmid_r", R, 0);
    check("rstmid_flags", FlagsOut, 0);
    pulses = 0;
    repeat (25) begin
      @(posedge Clk); #1;
      if (Done) pulses++;
    end
    check("rstmid_no_done", pulses, 0);
    op_check("post_rst_mul", 2'd1, 16'd300, 16'd300, 16'h0000, 16'h5F90, 16'h0008);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_muldiv_alu.md
Name: seq_muldiv_alu

Overview:
Multi-cycle, parametrised successor to the combinational signed multiply/divide ALU. It performs signed DIV, MUL, REM and MULH on L-bit two's-complement operands, using one shift-add or shift-subtract iteration per clock. It uses a Start/Busy/Done handshake and keeps the FlagsIn/FlagsOut pass-through scheme with the same four arithmetic flag bits. It sits in the execute stage and stalls the pipeline while Busy.

Parameters:
L, 16, operand/result/flag-word width (L >= 8)
OpBits, 2, width of Operation

Ports:
Clk  in  1  single clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  request; accepted only when Busy=0
Operation  in  OpBits  0=DIV, 1=MUL, 2=REM, 3=MULH
A  in  L  dividend / multiplicand, signed
B  in  L  divisor / multiplier, signed
FlagsIn  in  L  incoming flag word
Busy  out  1  operation in flight
Done  out  1  one-cycle pulse: R/FlagsOut valid
R  out  L  result, registered, held until next accepted Start
FlagsOut  out  L  flag word, registered, held like R

Behaviour:
- Reset (synchronous, active-high): state IDLE; Busy=0, Done=0, R=0, FlagsOut=0. Reset mid-operation aborts the operation, with no Done and no result update.
- Flag bit indices: 0 DivisionHasRemainder, 1 DivisionByZero, 2 DivisionOverflow, 3 MultiplicationOverflow. Bits [L-1:4] always equal the latched FlagsIn.
- States and transitions:
  - IDLE -> RUN on Start. Latch Operation, |A|, |B|, sign bits and FlagsIn; Busy=1; iteration counter = L-1.
  - RUN: one iteration per cycle, restoring division or shift-add multiply on magnitudes. Magnitudes are L-bit unsigned, so |-2^(L-1)| = 2^(L-1) is exact. RUN -> SIGN when counter reaches 0, giving L cycles in RUN.
  - SIGN: apply sign, compute flags, register R/FlagsOut. Done=1 for one cycle; Busy=0; -> IDLE.
- Latency: Start accepted at edge k; Done is high from edge k+L+1 to k+L+2. Latency is fixed for all operands, including B=0.
- Back-to-back: Start may be high in the Done cycle and is accepted, because Busy=0 in that cycle.
- Start while Busy=1 is ignored and not queued. A/B/Operation/FlagsIn changes while Busy are ignored.
- DIV: quotient truncates toward zero; sign = A[L-1]^B[L-1].
  - HasRemainder = (remainder != 0).
  - DivisionOverflow = 1 only for A=-2^(L-1), B=-1; R = -2^(L-1), wrapped.
  - MultiplicationOverflow passes from FlagsIn.
- REM: remainder takes the sign of A. Flags are as for DIV, except DivisionOverflow=0 (the remainder for -2^(L-1)/-1 is 0).
- B=0 (DIV/REM): R=0, DivisionByZero=1, HasRemainder=0, DivisionOverflow=0.
- MUL: R = low L bits of the 2L-bit signed product.
  - MultiplicationOverflow = 1 iff the product is not representable in L signed bits.
  - Division flags pass from FlagsIn.
- MULH: R = high L bits of the 2L-bit signed product. All four flags pass from FlagsIn.
- Operand zero: the sign is never applied to a zero magnitude, so -0 = 0 and no spurious overflow occurs.

Test Plan:
- L=16, MUL A=7, B=-3 (0xFFFD) -> Done exactly 17 cycles after accept edge, R=0xFFEB, flag3=0, FlagsIn[15:4]=0xABC passes through unchanged.
- DIV A=-7, B=2 -> R=0xFFFD, flag0=1; REM with same operands -> R=0xFFFF; DIV A=6, B=3 -> R=2, flag0=0.
- DIV A=5, B=0 -> R=0, flag1=1, latency 17. DIV A=0x8000, B=0xFFFF -> R=0x8000, flag2=1.
- MUL A=300, B=300 -> R=0x5F90, flag3=1; MULH same operands -> R=0x0001, flag3 equals FlagsIn[3].
- Timing: Start pulsed again at cycle 5 of a busy operation with different operands -> ignored, first result unchanged. Start held high in the Done cycle -> second operation accepted, its Done 17 cycles later.
- Reset asserted for one cycle at RUN cycle 8 -> next cycle Busy=0, Done never pulses, R=0, FlagsOut=0; a subsequent op completes normally.
